// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, widths and lane-mask helper for the memory responder
package mem_pkg;

   localparam int DATA_W     = 16;
   localparam int ADDR_BUS_W = 32;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic [DATA_W-1:0] lane_mask(input logic lb, input logic hb);
      return {{8{hb}}, {8{lb}}};
   endfunction

endpackage

// File: rtl/mem_responder_array.sv
// rtl/mem_responder_array.sv - single-port halfword array with byte-lane writes and registered read
module mem_responder_array
   import mem_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clock_i,
   input  logic              reset_n_i,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              lb_i,
   input  logic              hb_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rd_mask;

   assign rd_mask = lane_mask(lb_i, hb_i);

   // Contents are deliberately not reset; only the read register is.
   always_ff @(posedge clock_i) begin
      if (we_i && lb_i) begin
         mem_q[addr_i][7:0] <= wdata_i[7:0];
      end
      if (we_i && hb_i) begin
         mem_q[addr_i][15:8] <= wdata_i[15:8];
      end
   end

   // Disabled lanes read as zero, so a read with both lanes off yields 16'h0000.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i] & rd_mask;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - request FSM, wait-state counter, range check and registered outputs
module mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [ADDR_BUS_W-1:0] addr,
   input  logic [DATA_W-1:0]     value,
   input  logic                  read,
   input  logic                  write,
   input  logic                  lb,
   input  logic                  hb,
   output logic                  busy,
   output logic                  ready,
   output logic [DATA_W-1:0]     rdata,
   output logic                  err
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]  idx_q;
   logic [DATA_W-1:0]  wdata_q;
   logic               lb_q, hb_q, wr_q, oor_q;
   logic               busy_q, busy_d;
   logic               ready_q, ready_d;
   logic               err_q, err_d;
   logic               accept, access, addr_oor;
   logic               arr_we, arr_re, arr_lb, arr_hb;
   logic               unused_addr_lsb;

   assign unused_addr_lsb = addr[0];
   assign addr_oor = |addr[ADDR_BUS_W-1:ADDR_W+1];
   assign accept   = (state_q == ST_IDLE) && (read || write);
   assign access   = (state_q == ST_WAIT) && (cnt_q == '0);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (read || write) begin
               state_d = ST_WAIT;
               cnt_d   = CNT_W'(WAIT_CYCLES);
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Out-of-range accesses still strobe the array on reads, with lanes off, to zero rdata.
   always_comb begin
      busy_d  = (state_d != ST_IDLE);
      ready_d = access;
      err_d   = access && oor_q;
      arr_we  = access && wr_q && !oor_q;
      arr_re  = access && !wr_q;
      arr_lb  = lb_q && !oor_q;
      arr_hb  = hb_q && !oor_q;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         err_q   <= err_d;
      end
   end

   // Simultaneous read and write is latched as a write.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         idx_q   <= '0;
         wdata_q <= '0;
         lb_q    <= 1'b0;
         hb_q    <= 1'b0;
         wr_q    <= 1'b0;
         oor_q   <= 1'b0;
      end else if (accept) begin
         idx_q   <= addr[ADDR_W:1];
         wdata_q <= value;
         lb_q    <= lb;
         hb_q    <= hb;
         wr_q    <= write;
         oor_q   <= addr_oor;
      end
   end

   mem_responder_array #(
      .ADDR_W(ADDR_W)
   ) u_array (
      .clock_i  (clock),
      .reset_n_i(reset_n),
      .we_i     (arr_we),
      .re_i     (arr_re),
      .addr_i   (idx_q),
      .wdata_i  (wdata_q),
      .lb_i     (arr_lb),
      .hb_i     (arr_hb),
      .rdata_o  (rdata)
   );

   assign busy  = busy_q;
   assign ready = ready_q;
   assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder
module tb_mem_responder;

   localparam int WC = 2;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;

   logic [31:0] addr = '0;
   logic [15:0] value = '0;
   logic        read = 1'b0, write = 1'b0, lb = 1'b0, hb = 1'b0;
   logic        busy, ready, err;
   logic [15:0] rdata;

   logic [31:0] addr0 = '0;
   logic [15:0] value0 = '0;
   logic        read0 = 1'b0, write0 = 1'b0, lb0 = 1'b0, hb0 = 1'b0;
   logic        busy0, ready0, err0;
   logic [15:0] rdata0;

   int          n_cmp = 0;
   int          n_err = 0;

   logic [15:0] mem_m [1024];
   logic [15:0] rdata_m = 16'h0000;

   always #5 clock = ~clock;

   mem_responder #(.ADDR_W(10), .WAIT_CYCLES(WC)) u_dut (
      .clock(clock), .reset_n(reset_n), .addr(addr), .value(value),
      .read(read), .write(write), .lb(lb), .hb(hb),
      .busy(busy), .ready(ready), .rdata(rdata), .err(err)
   );

   mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
      .clock(clock), .reset_n(reset_n), .addr(addr0), .value(value0),
      .read(read0), .write(write0), .lb(lb0), .hb(hb0),
      .busy(busy0), .ready(ready0), .rdata(rdata0), .err(err0)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One complete access on u_dut, checked against the reference array.
   task automatic do_access(input bit rd, input bit wr, input logic [31:0] a,
                            input logic [15:0] v, input bit l, input bit h);
      bit          oor;
      int          idx;
      int          n;
      bit          seen;
      logic [15:0] m;
      oor = (a[31:11] != 0);
      idx = int'(a[10:1]);
      m   = {{8{h}}, {8{l}}};
      if (wr) begin
         if (!oor) mem_m[idx] = (mem_m[idx] & ~m) | (v & m);
      end else if (rd) begin
         rdata_m = oor ? 16'h0000 : (mem_m[idx] & m);
      end
      @(negedge clock);
      addr = a; value = v; read = rd; write = wr; lb = l; hb = h;
      @(negedge clock);
      read = 1'b0; write = 1'b0;
      addr = $urandom; value = 16'($urandom); lb = 1'($urandom); hb = 1'($urandom);
      n = 0;
      seen = 0;
      while (!seen && n < 20) begin
         if (ready) begin
            seen = 1;
         end else begin
            check("busy_wait", 32'(busy), 32'd1);
            @(negedge clock);
            n++;
         end
      end
      if (!seen) begin
         check("ready_timeout", 32'd0, 32'd1);
      end else begin
         check("latency", n, WC + 1);
         check("busy_done", 32'(busy), 32'd1);
         check("err", 32'(err), 32'(oor));
         check("rdata", 32'(rdata), 32'(rdata_m));
      end
      @(negedge clock);
      check("ready_drop", 32'(ready), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
      check("rdata_hold", 32'(rdata), 32'(rdata_m));
   endtask

   initial begin
      logic [15:0] pre;
      logic [31:0] a;
      int          op;
      int          pulses[$];
      int          n;
      bit          seen;

      #1 reset_n = 1'b0;
      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      for (int i = 0; i < 16; i++) do_access(0, 1, 32'(i * 2), 16'($urandom), 1, 1);

      do_access(0, 1, 32'h0000_0004, 16'hBEEF, 1, 1);
      do_access(1, 0, 32'h0000_0004, 16'h0000, 1, 1);
      check("beef", 32'(rdata), 32'h0000_BEEF);
      do_access(0, 1, 32'h0000_0004, 16'h1234, 0, 1);
      do_access(1, 0, 32'h0000_0004, 16'h0000, 1, 1);
      check("hb_merge", 32'(rdata), 32'h0000_12EF);
      do_access(1, 0, 32'h0000_0005, 16'h0000, 1, 0);
      check("lb_only", 32'(rdata), 32'h0000_00EF);
      do_access(1, 1, 32'h0000_0004, 16'h5555, 1, 1);
      check("rw_keep", 32'(rdata), 32'h0000_00EF);
      do_access(1, 0, 32'h0000_0004, 16'h0000, 1, 1);
      check("rw_wrote", 32'(rdata), 32'h0000_5555);
      do_access(1, 0, 32'h0001_0000, 16'h0000, 1, 1);
      check("oor_rdata", 32'(rdata), 32'h0000_0000);
      do_access(0, 1, 32'h0001_0000, 16'hDEAD, 1, 1);
      do_access(1, 0, 32'h0000_0000, 16'h0000, 1, 1);
      do_access(0, 1, 32'h0000_0006, 16'h7777, 0, 0);
      do_access(1, 0, 32'h0000_0006, 16'h0000, 1, 1);

      // Reset in the middle of a write: nothing lands in the array.
      pre = mem_m[2];
      @(negedge clock);
      addr = 32'h4; value = 16'hAAAA; write = 1'b1; lb = 1'b1; hb = 1'b1;
      @(negedge clock);
      write = 1'b0;
      check("mid_busy", 32'(busy), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("async_busy", 32'(busy), 32'd0);
      check("async_ready", 32'(ready), 32'd0);
      check("async_err", 32'(err), 32'd0);
      check("async_rdata", 32'(rdata), 32'd0);
      rdata_m = 16'h0000;
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         check("no_ready_after_rst", 32'(ready), 32'd0);
      end
      do_access(1, 0, 32'h0000_0004, 16'h0000, 1, 1);
      check("rst_no_write", 32'(rdata), 32'(pre));

      for (int i = 0; i < 60; i++) begin
         op = int'($urandom_range(0, 3));
         a = 32'($urandom_range(0, 15) * 2) | 32'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(11, 31));
         do_access(op != 1, op == 1 || op == 2, a, 16'($urandom),
                   1'($urandom), 1'($urandom));
      end

      // Zero wait states with a continuously held read.
      @(negedge clock);
      addr0 = 32'h6; value0 = 16'h3C5A; write0 = 1'b1; lb0 = 1'b1; hb0 = 1'b1;
      @(negedge clock);
      write0 = 1'b0;
      seen = 0;
      n = 0;
      while (!seen && n < 10) begin
         if (ready0) seen = 1;
         else begin
            @(negedge clock);
            n++;
         end
      end
      check("wc0_write_ready", 32'(seen), 32'd1);
      @(negedge clock);
      read0 = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clock);
         if (ready0) begin
            pulses.push_back(i);
            check("wc0_rdata", 32'(rdata0), 32'h0000_3C5A);
            check("wc0_err", 32'(err0), 32'd0);
         end
      end
      read0 = 1'b0;
      check("wc0_pulses", pulses.size(), 10);
      if (pulses.size() > 0) check("wc0_first", pulses[0], 1);
      for (int i = 1; i < pulses.size(); i++) check("wc0_gap", pulses[i] - pulses[i-1], 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the 16-bit data bus driven by the memory arbiter. Samples one read or write request at a time, stores halfwords with per-byte lane enables in an internal array, and answers after a programmable number of wait states. Its `busy` output feeds the arbiter's stall logic; its `ready` and `rdata` outputs return results to the fetch/decode/memory stages.

## Interface
- `ADDR_W`, default 10: halfword index width; the array holds 2^ADDR_W halfwords.
- `WAIT_CYCLES`, default 2: wait states per access, legal range 0..15.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `addr`  in  32  byte address; bit 0 ignored; halfword index is `addr[ADDR_W:1]`.
- `value`  in  16  write data.
- `read`  in  1  read request.
- `write`  in  1  write request.
- `lb`  in  1  low-byte lane enable (bits 7:0).
- `hb`  in  1  high-byte lane enable (bits 15:8).
- `busy`  out  1  high whenever state is not IDLE.
- `ready`  out  1  one-cycle completion pulse.
- `rdata`  out  16  read result; held until the next read completes.
- `err`  out  1  out-of-range flag; valid only while `ready` is high.

## Operation
- States: IDLE, WAIT, DONE. Wait counter is 4 bits.
- IDLE: if `read|write` is high at an edge, latch `addr`, `value`, `lb`, `hb` and the op; load counter with `WAIT_CYCLES`; go to WAIT.
- Simultaneous `read` and `write`: treated as a write. `rdata` is not updated.
- WAIT: at each edge, if counter is 0, perform the access and go to DONE; otherwise decrement the counter.
- Access rules:
  - Write: only the enabled lanes of the array entry are updated.
  - Read: `rdata` takes the array entry with disabled lanes forced to 8'h00.
- Out of range (`addr[31:ADDR_W+1]` is not zero): no array update; `rdata` is 16'h0000 on a read; `err` is 1 in DONE.
- DONE: `ready`=1 for exactly one cycle. Requests are ignored. Unconditional transition to IDLE.
- The requester must drop or change its request on the edge that samples `ready`. A request still high in IDLE is accepted as a new access.
- Write with `lb`=`hb`=0: completes normally, array unchanged.
- Inputs may change freely after the accept edge; only the latched copies are used.

## Timing
- Reset (async assert, any state, including mid-access): state IDLE, counter 0, `busy`=0, `ready`=0, `err`=0, `rdata`=16'h0000. The in-flight access is abandoned and no array write occurs. Array contents are not reset.
- Accept at edge k → `busy` high from k. Access is performed at edge k+1+WAIT_CYCLES. `ready` is high in the cycle following that edge. IDLE is re-entered at edge k+2+WAIT_CYCLES.
- Back-to-back minimum period: WAIT_CYCLES+3 cycles per access.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Package `mem_pkg`:
  - State enum (IDLE/WAIT/DONE).
  - `DATA_W`=16, `ADDR_BUS_W`=32, `CNT_W`=4.
  - Lane-mask helper function (lb, hb → 16-bit mask).
- Sub-module `mem_responder_array`:
  - Synchronous single-port halfword array with `we`, `lb`, `hb`, registered read.
  - Instantiated once.
- FSM, counter, range check and output registers stay in `mem_responder`.

## Test plan
- Reset, then write `addr`=0x0000_0004, `value`=0xBEEF, `lb`=`hb`=1, WAIT_CYCLES=2 → `busy` high for 4 cycles, `ready` pulse at edge k+3, `err`=0. A subsequent full read returns `rdata`=0xBEEF.
- Write 0x1234 with `hb` only to that same address, then read with both lanes → 0x12EF. Read with `lb` only → 0x00EF.
- `read` and `write` both high, `value`=0x5555 → array becomes 0x5555 and `rdata` keeps its previous value.
- Read at `addr`=0x0001_0000 with ADDR_W=10 → `ready` with `err`=1, `rdata`=0x0000. Write to the same address leaves the array unchanged.
- Assert `reset_n`=0 during WAIT of a write of 0xAAAA → all outputs zero immediately and no `ready` follows. Reading the location afterwards returns its pre-write value.
- WAIT_CYCLES=0 with `read` held high continuously → `ready` every 3 cycles, one pulse per access.
